// File: rtl/cmp_result_monitor.sv
// rtl/cmp_result_monitor.sv - registered checker for 8-bit magnitude comparator flags
//
// Consumer stage directly downstream of the comparator. It registers the
// comparator flags and the operands. It checks that the flags are one-hot,
// tracks how long an identical result repeats, and raises an alarm once
// A>B has persisted long enough.
//
// Optional feature: define CMP_STATS_EN to add per-result sample counters
// and their clear input.
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   in_valid   comparator flags/operands valid this cycle
//   A, B       operands as seen by the comparator
//   AiB/AeB/AsB comparator flags (A>B, A=B, A<B)
//   out_valid  registered in_valid
//   res_code   00 none/illegal, 01 GT, 10 EQ, 11 LT
//   win_val    larger operand of the last legal sample
//   run_len    consecutive identical legal results, saturating
//   alarm      high while the persistence FSM is in ALARM
//   err_pulse  one-cycle pulse on an illegal flag combination
//   err_sticky latched illegal-flag indication, cleared only by RST
//   stats_clr, gt_cnt, eq_cnt, lt_cnt  (CMP_STATS_EN only) result counters

module cmp_result_monitor #(
  parameter int PERSIST = 4,
  parameter int CLEAR   = 2,
  parameter int RUN_W   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic             AiB,
  input  logic             AeB,
  input  logic             AsB,
  output logic             out_valid,
  output logic [1:0]       res_code,
  output logic [7:0]       win_val,
  output logic [RUN_W-1:0] run_len,
  output logic             alarm,
  output logic             err_pulse,
  output logic             err_sticky
`ifdef CMP_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [15:0]      gt_cnt,
  output logic [15:0]      eq_cnt,
  output logic [15:0]      lt_cnt
`endif
);

  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARMED, ALRM} state_t;

  state_t     state, state_d;
  logic [3:0] pc, pc_d, cc, cc_d;
  logic       legal, is_gt, is_lt, sample_ok;
  logic [1:0] code;
  logic [1:0] last_code;

  // Flag decode: only exact one-hot patterns are legal results.
  always_comb begin
    legal = 1'b0;
    code  = 2'b00;
    case ({AiB, AeB, AsB})
      3'b100:  begin legal = 1'b1; code = 2'b01; end
      3'b010:  begin legal = 1'b1; code = 2'b10; end
      3'b001:  begin legal = 1'b1; code = 2'b11; end
      default: begin legal = 1'b0; code = 2'b00; end
    endcase
    is_gt     = (code == 2'b01);
    is_lt     = (code == 2'b11);
    sample_ok = in_valid && legal;
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      pc    <= 4'd0;
      cc    <= 4'd0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      cc    <= cc_d;
    end
  end

  // FSM next state: illegal or idle cycles leave state and counters untouched.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    cc_d    = cc;
    if (sample_ok) begin
      case (state)
        IDLE: begin
          if (is_gt) begin
            pc_d    = 4'd1;
            state_d = (PERSIST == 1) ? ALRM : ARMED;
          end
        end
        ARMED: begin
          if (is_gt) begin
            pc_d = pc + 4'd1;
            if (pc + 4'd1 == 4'(PERSIST)) state_d = ALRM;
          end else begin
            pc_d    = 4'd0;
            state_d = IDLE;
          end
        end
        ALRM: begin
          if (is_gt) begin
            cc_d = 4'd0;
          end else if (cc + 4'd1 == 4'(CLEAR)) begin
            cc_d    = 4'd0;
            pc_d    = 4'd0;
            state_d = IDLE;
          end else begin
            cc_d = cc + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: alarm follows the registered state, so it changes on the
  // same edge as the transition.
  always_comb begin
    alarm = (state == ALRM);
  end

  // Result datapath. last_code resets to 00, which never matches a legal
  // code, so the first legal sample after reset always starts a new run.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid  <= 1'b0;
      res_code   <= 2'b00;
      win_val    <= 8'h00;
      run_len    <= '0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      last_code  <= 2'b00;
    end else begin
      out_valid <= in_valid;
      err_pulse <= in_valid && !legal;
      if (in_valid) begin
        if (legal) begin
          res_code  <= code;
          win_val   <= is_lt ? B : A;
          last_code <= code;
          if (code != last_code) begin
            run_len <= RUN_ONE;
          end else if (run_len != RUN_MAX) begin
            run_len <= run_len + RUN_ONE;
          end
        end else begin
          res_code   <= 2'b00;
          err_sticky <= 1'b1;
        end
      end
    end
  end

`ifdef CMP_STATS_EN
  // A clear wins over a sample arriving in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST || stats_clr) begin
      gt_cnt <= 16'd0;
      eq_cnt <= 16'd0;
      lt_cnt <= 16'd0;
    end else if (sample_ok) begin
      case (code)
        2'b01:   if (gt_cnt != 16'hFFFF) gt_cnt <= gt_cnt + 16'd1;
        2'b10:   if (eq_cnt != 16'hFFFF) eq_cnt <= eq_cnt + 16'd1;
        2'b11:   if (lt_cnt != 16'hFFFF) lt_cnt <= lt_cnt + 16'd1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_cmp_result_monitor.sv
// tb/tb_cmp_result_monitor.sv - scoreboard bench for cmp_result_monitor
module tb_cmp_result_monitor;

  localparam int PERSIST = 4;
  localparam int CLEAR   = 2;
  localparam int RUN_W   = 3;
  localparam int RMAX    = (1 << RUN_W) - 1;

  localparam logic [2:0] F_GT = 3'b100;
  localparam logic [2:0] F_EQ = 3'b010;
  localparam logic [2:0] F_LT = 3'b001;

  logic             clk;
  logic             RST, in_valid, AiB, AeB, AsB;
  logic [7:0]       A, B;
  logic             out_valid, alarm, err_pulse, err_sticky;
  logic [1:0]       res_code;
  logic [7:0]       win_val;
  logic [RUN_W-1:0] run_len;
`ifdef CMP_STATS_EN
  logic             stats_clr;
  logic [15:0]      gt_cnt, eq_cnt, lt_cnt;
`endif

  cmp_result_monitor #(.PERSIST(PERSIST), .CLEAR(CLEAR), .RUN_W(RUN_W)) dut (
    .CLK(clk), .RST(RST), .in_valid(in_valid), .A(A), .B(B),
    .AiB(AiB), .AeB(AeB), .AsB(AsB),
    .out_valid(out_valid), .res_code(res_code), .win_val(win_val),
    .run_len(run_len), .alarm(alarm), .err_pulse(err_pulse),
    .err_sticky(err_sticky)
`ifdef CMP_STATS_EN
    , .stats_clr(stats_clr), .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       ov;
    bit [1:0] code;
    bit [7:0] win;
    int       run;
    bit       alarm;
    bit       ep;
    bit       es;
    int       gt, eq, lt;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   last_code, gt_streak, clr_streak;
  int   n_tests, n_fail;
  bit   started, done;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // Reference model: result rules expressed as run lengths and streaks.
  task automatic model(input bit r, input bit v, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] f, input bit sc);
    int code;
    if (r) begin
      m = '{default: 0};
      last_code = 0; gt_streak = 0; clr_streak = 0;
      return;
    end
    code = (f == F_GT) ? 1 : (f == F_EQ) ? 2 : (f == F_LT) ? 3 : 0;
    if (sc) begin
      m.gt = 0; m.eq = 0; m.lt = 0;
    end else if (v && code == 1) m.gt = sat_inc(m.gt, 65535);
    else if (v && code == 2) m.eq = sat_inc(m.eq, 65535);
    else if (v && code == 3) m.lt = sat_inc(m.lt, 65535);
    m.ov = v;
    m.ep = 0;
    if (!v) return;
    if (code == 0) begin
      m.code = 0; m.ep = 1; m.es = 1;
      return;
    end
    m.code = 2'(code);
    m.win  = (code == 3) ? b : a;
    m.run  = (code == last_code) ? sat_inc(m.run, RMAX) : 1;
    last_code = code;
    if (!m.alarm) begin
      gt_streak = (code == 1) ? gt_streak + 1 : 0;
      if (gt_streak >= PERSIST) begin m.alarm = 1; clr_streak = 0; end
    end else begin
      clr_streak = (code == 1) ? 0 : clr_streak + 1;
      if (clr_streak >= CLEAR) begin m.alarm = 0; gt_streak = 0; clr_streak = 0; end
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] f, input bit sc);
    @(negedge clk);
    RST = r; in_valid = v; A = a; B = b; {AiB, AeB, AsB} = f;
`ifdef CMP_STATS_EN
    stats_clr = sc;
`endif
    model(r, v, a, b, f, sc);
    if (!r && v) q.push_back(m);
    started = 1;
  endtask

  task automatic compare(input exp_t e);
    chk("out_valid", int'(out_valid), int'(e.ov));
    chk("res_code", int'(res_code), int'(e.code));
    chk("win_val", int'(win_val), int'(e.win));
    chk("run_len", int'(run_len), e.run);
    chk("alarm", int'(alarm), int'(e.alarm));
    chk("err_pulse", int'(err_pulse), int'(e.ep));
    chk("err_sticky", int'(err_sticky), int'(e.es));
`ifdef CMP_STATS_EN
    chk("gt_cnt", int'(gt_cnt), e.gt);
    chk("eq_cnt", int'(eq_cnt), e.eq);
    chk("lt_cnt", int'(lt_cnt), e.lt);
`endif
  endtask

  // Monitor: pairs each DUT output beat with the oldest expected beat; idle
  // cycles are checked against the model's held state.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (started && !done) begin
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
          end else begin
            e = q.pop_front();
            compare(e);
          end
        end else begin
          compare(m);
        end
      end
    end
  end

  initial begin
    logic [7:0] a, b;
    logic [2:0] f;
    n_tests = 0; n_fail = 0; started = 0; done = 0;
    m = '{default: 0};
    last_code = 0; gt_streak = 0; clr_streak = 0;

    // reset, then alarm entry
    step(1, 0, 8'h00, 8'h00, 3'b000, 0);
    step(1, 0, 8'h00, 8'h00, 3'b000, 0);
    step(0, 0, 8'h00, 8'h00, 3'b000, 0);
    repeat (4) step(0, 1, 8'hA0, 8'h10, F_GT, 0);
    // hysteresis and exit
    step(0, 1, 8'h05, 8'h30, F_LT, 0);
    step(0, 1, 8'hA0, 8'h10, F_GT, 0);
    step(0, 1, 8'h05, 8'h30, F_LT, 0);
    step(0, 1, 8'h05, 8'h30, F_LT, 0);
    step(0, 0, 8'h00, 8'h00, 3'b000, 0);
    // illegal flags mid-run, then the run continues
    step(0, 1, 8'hA0, 8'h10, F_GT, 0);
    step(0, 1, 8'hA0, 8'h10, F_GT, 0);
    step(0, 1, 8'h33, 8'h22, 3'b110, 0);
    step(0, 1, 8'hA0, 8'h10, F_GT, 0);
    step(0, 1, 8'h00, 8'h00, 3'b000, 0);
    step(0, 1, 8'h00, 8'h00, 3'b111, 0);
    // run length saturation
    repeat (9) step(0, 1, 8'h42, 8'h42, F_EQ, 0);
    // reset during an in-flight count
    step(0, 1, 8'hA0, 8'h10, F_GT, 0);
    step(0, 1, 8'hA0, 8'h10, F_GT, 0);
    step(1, 1, 8'hA0, 8'h10, F_GT, 0);
    step(0, 0, 8'h00, 8'h00, 3'b000, 0);
    // stats counters and clear-wins
    repeat (3) step(0, 1, 8'h90, 8'h10, F_GT, 0);
    step(0, 1, 8'h11, 8'h11, F_EQ, 0);
    step(0, 1, 8'h01, 8'h70, F_LT, 1);
    step(0, 0, 8'h00, 8'h00, 3'b000, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      if ($urandom_range(0, 9) == 0) f = 3'($urandom);
      else f = (a > b) ? F_GT : (a == b) ? F_EQ : F_LT;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, a, b, f,
           $urandom_range(0, 29) == 0);
    end

    step(0, 0, 8'h00, 8'h00, 3'b000, 0);
    step(0, 0, 8'h00, 8'h00, 3'b000, 0);
    @(posedge clk);
    #2;
    done = 1;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_result_monitor.md
Name: cmp_result_monitor

Overview:
- Clocked consumer stage placed directly downstream of the 8-bit magnitude comparator.
- Registers the comparator's three flags (AiB, AeB, AsB) together with the operand bytes, and checks that the flags are one-hot.
- Tracks the run length of identical results.
- Runs a persistence/hysteresis FSM that raises an alarm when A>B holds for a programmable number of consecutive samples.

Parameters:
- PERSIST, 4: consecutive valid A>B samples needed to enter ALARM; legal range 1..15.
- CLEAR, 2: consecutive valid non-A>B samples needed to leave ALARM; legal range 1..15.
- RUN_W, 8: width of the run-length counter.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  comparator flags and operands are valid this cycle.
- A  in  8  operand A as presented to the comparator.
- B  in  8  operand B as presented to the comparator.
- AiB  in  1  comparator flag, A>B.
- AeB  in  1  comparator flag, A=B.
- AsB  in  1  comparator flag, A<B.
- out_valid  out  1  registered copy of in_valid.
- res_code  out  2  00 none/invalid, 01 GT, 10 EQ, 11 LT.
- win_val  out  8  larger operand of the last legal sample.
- run_len  out  RUN_W  count of consecutive identical legal results.
- alarm  out  1  high while the FSM is in ALARM.
- err_pulse  out  1  one-cycle pulse for an illegal flag combination.
- err_sticky  out  1  set on any illegal combination; cleared only by RST.

Behaviour:
- Reset (RST=1 at a rising edge): all outputs 0; FSM to IDLE; internal counters and last-code register cleared. Reset has priority over every event in the same cycle, including mid-alarm or mid-count.
- Latency: every output updates on the edge after in_valid=1, so it is registered one cycle after the sample. With in_valid=0: out_valid=0, err_pulse=0, and every other output holds its value.
- Legal sample: exactly one of {AiB, AeB, AsB} is 1.
  - res_code is set from the asserted flag.
  - win_val = A for GT or EQ, B for LT.
- Illegal sample (zero flags, or two or more flags):
  - res_code=00, err_pulse=1, err_sticky=1.
  - win_val, run_len, FSM state and FSM counters are unchanged; the sample is invisible to the FSM.
- run_len:
  - Set to 1 when the legal code differs from the last legal code, or on the first legal sample after reset.
  - Incremented when the code repeats.
  - Saturates at 2^RUN_W-1 and never wraps.
- FSM, with a 4-bit persist counter pc and a 4-bit clear counter cc (both advance only on legal samples):
  - IDLE:
    - GT: pc=1; go to ALARM if PERSIST==1, else to ARMED.
    - EQ/LT: stay in IDLE.
  - ARMED:
    - GT: pc+1; enter ALARM when pc+1==PERSIST.
    - EQ/LT: pc=0, back to IDLE.
  - ALARM (alarm=1):
    - EQ/LT: cc+1; when cc+1==CLEAR go to IDLE with cc=0 and pc=0.
    - GT: cc=0, stay in ALARM.
- alarm is asserted on the same edge that moves the FSM into ALARM, and deasserted on the edge that moves it into IDLE.

Optional Feature:
- Macro: CMP_STATS_EN.
- When defined:
  - Extra ports: stats_clr (in, 1), gt_cnt (out, 16), eq_cnt (out, 16), lt_cnt (out, 16).
  - Each legal sample increments its matching counter, saturating at 16'hFFFF.
  - stats_clr=1 zeroes all three counters on that edge. If a legal sample arrives in the same cycle, stats_clr wins and the sample is not counted.
  - RST also zeroes the counters.
- When undefined: none of these ports or counters exist, and all other behaviour is identical.

Test Plan:
- Reset check: RST high for 2 cycles, then low → all outputs 0, FSM in IDLE.
- Alarm entry (PERSIST=4, CLEAR=2): 4 valid GT samples (A=8'hA0, B=8'h10) → alarm rises on the 4th output cycle; run_len=4; win_val=8'hA0.
- Hysteresis and exit: in ALARM, send LT, GT, LT, LT (A=8'h05, B=8'h30) → alarm stays high through LT, GT, LT and falls after the final LT; win_val=8'h30; run_len=2.
- Illegal flags: AiB=AeB=1 mid-run → err_pulse high for exactly 1 cycle, err_sticky=1, res_code=00, run_len and FSM unchanged. A following GT then continues the run count.
- Saturation (RUN_W=3): 9 consecutive EQ samples → run_len reaches 7 and holds at 7.
- Reset during an in-flight count: 2 GT samples, then RST together with in_valid=1/GT → all outputs 0 next cycle. With CMP_STATS_EN: 3 GT + 1 EQ gives gt_cnt=3, eq_cnt=1; stats_clr asserted with a valid LT gives all counters 0.
